// File: rtl/serial_add_if.sv
// Host-side handshake bundle for the bit-serial adder sequencer.
// Optional subtract input is present only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
`ifdef SERIAL_ADD_SUB_EN
        sub,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
`ifdef SERIAL_ADD_SUB_EN
        sub,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: WIDTH-bit add, one bit per clock, LSB first, through one
// shared full adder built from two half adders. Define SERIAL_ADD_SUB_EN for subtract.
module h_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_add_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] a_sh_r, a_sh_nxt_s;
    logic [WIDTH-1:0] b_sh_r, b_sh_nxt_s;
    logic [WIDTH-1:0] sum_r, sum_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic             carry_r, carry_nxt_s;
    logic             cout_r, cout_nxt_s;
    logic             busy_r, done_r;
    logic             s0_s, c0_s, s1_s, c1_s;
    logic             carry_init_s;
    logic [WIDTH-1:0] b_load_s;

    h_adder ha0 (.x(a_sh_r[0]), .y(b_sh_r[0]), .s(s0_s), .c(c0_s));
    h_adder ha1 (.x(s0_s),      .y(carry_r),   .s(s1_s), .c(c1_s));

    // Subtraction is a + ~b + 1: invert b and seed the carry with the sub flag.
`ifdef SERIAL_ADD_SUB_EN
    assign carry_init_s = bus.sub;
    assign b_load_s     = bus.sub ? ~bus.b : bus.b;
`else
    assign carry_init_s = 1'b0;
    assign b_load_s     = bus.b;
`endif

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        a_sh_nxt_s  = a_sh_r;
        b_sh_nxt_s  = b_sh_r;
        sum_nxt_s   = sum_r;
        cnt_nxt_s   = cnt_r;
        carry_nxt_s = carry_r;
        cout_nxt_s  = cout_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_nxt_s  = bus.a;
                    b_sh_nxt_s  = b_load_s;
                    carry_nxt_s = carry_init_s;
                    cnt_nxt_s   = {CW{1'b0}};
                    sum_nxt_s   = {WIDTH{1'b0}};
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_nxt_s   = {s1_s, sum_r[WIDTH-1:1]};
                carry_nxt_s = c0_s | c1_s;
                a_sh_nxt_s  = {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_nxt_s  = {1'b0, b_sh_r[WIDTH-1:1]};
                cnt_nxt_s   = cnt_r + CW'(1);
                if (cnt_r == CW'(WIDTH - 1)) begin
                    cout_nxt_s  = c0_s | c1_s;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            a_sh_r  <= a_sh_nxt_s;
            b_sh_r  <= b_sh_nxt_s;
            sum_r   <= sum_nxt_s;
            cnt_r   <= cnt_nxt_s;
            carry_r <= carry_nxt_s;
            cout_r  <= cout_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule
